// File: rtl/spi_rx_fifo.sv
// Receive byte FIFO behind the SPI wrapper with level, full/empty and sticky error flags.
// Define SPI_RX_FIFO_IRQ_EN to build the registered level/overflow interrupt.
module spi_rx_fifo #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int IRQ_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_buff,
    input  logic              rx_valid,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              flush,
    input  logic              clr_err,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              irq
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    generate
        if (DEPTH < 2 || (1 << ADDR_W) != DEPTH ||
            IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_param
            $error("spi_rx_fifo: illegal parameter combination");
        end
    endgenerate

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic is_empty, is_full;
    logic pop_ok, push_ok, ovf_evt, udf_evt;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == FULL_LVL);

    // A pop frees its slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign pop_ok  = rd_en & ~is_empty;
    assign push_ok = rx_valid & (~is_full | pop_ok);
    assign ovf_evt = rx_valid & ~push_ok;
    assign udf_evt = rd_en & is_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = (overflow_q & ~clr_err) | ovf_evt;
        underflow_d = (underflow_q & ~clr_err) | udf_evt;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level_d = level_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= rx_buff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SPI_RX_FIFO_IRQ_EN
    localparam logic [ADDR_W:0] THRESH_LVL = (ADDR_W + 1)'(IRQ_THRESH);

    logic irq_q, irq_d;

    assign irq_d = (level_d >= THRESH_LVL) | overflow_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign level     = level_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Bench for spi_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_spi_rx_fifo;

    localparam int DEPTH      = 8;
    localparam int ADDR_W     = 3;
    localparam int IRQ_THRESH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      rx_buff = 8'h00;
    logic            rx_valid = 1'b0;
    logic            rd_en = 1'b0;
    logic            flush = 1'b0;
    logic            clr_err = 1'b0;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic [ADDR_W:0] level;
    logic            empty, full, overflow, underflow, irq;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] m_data;
    bit         m_vld, m_ovf, m_udf, m_irq;

    spi_rx_fifo #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IRQ_THRESH(IRQ_THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_buff(rx_buff), .rx_valid(rx_valid),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .flush(flush), .clr_err(clr_err), .level(level), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_data = 8'h00;
        m_vld = 0;
        m_ovf = 0;
        m_udf = 0;
        m_irq = 0;
    endtask

    task automatic tick(input bit rv, input logic [7:0] b, input bit rd,
                        input bit fl, input bit ce);
        int sz;
        bit pop, push;
        rx_valid = rv;
        rx_buff  = b;
        rd_en    = rd;
        flush    = fl;
        clr_err  = ce;
        @(posedge clk);
        sz   = q.size();
        pop  = rd && sz > 0;
        push = rv && (sz < DEPTH || pop);
        if (fl) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
            m_vld = 0;
        end else begin
            m_vld = pop;
            if (pop) m_data = q.pop_front();
            if (push) q.push_back(b);
            m_ovf = (m_ovf && !ce) || (rv && !push);
            m_udf = (m_udf && !ce) || (rd && sz == 0);
        end
`ifdef SPI_RX_FIFO_IRQ_EN
        m_irq = (q.size() >= IRQ_THRESH) || m_ovf;
`else
        m_irq = 0;
`endif
        #1;
        rx_valid = 0;
        rd_en    = 0;
        flush    = 0;
        clr_err  = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
            rd_valid !== 1'b0 || rd_data !== 8'h00 ||
            overflow !== 1'b0 || underflow !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset: lvl=%0d e=%b f=%b v=%b d=%h o=%b u=%b i=%b",
                     level, empty, full, rd_valid, rd_data, overflow, underflow, irq);
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        tick(1, 8'hA5, 0, 0, 0);
        checks++;
        if (level !== 4'd1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL basic_push: level=%0d empty=%b want 1/0", level, empty);
        end
        tick(0, 8'h00, 1, 0, 0);
        checks++;
        if (rd_data !== 8'hA5 || rd_valid !== 1'b1 || empty !== 1'b1) begin
            failures++;
            $display("FAIL basic_pop: data=%h vld=%b empty=%b want a5/1/1",
                     rd_data, rd_valid, empty);
        end
        tick(0, 8'h00, 0, 0, 0);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
            failures++;
            $display("FAIL basic_hold: vld=%b data=%h want 0/a5", rd_valid, rd_data);
        end
    endtask

    task automatic test_order_wrap();
        int errs = 0;
        for (int i = 1; i <= 6; i++) tick(1, 8'(i), 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(0, 8'h00, 1, 0, 0);
            if (rd_data !== 8'(i) || rd_valid !== 1'b1) errs++;
        end
        for (int i = 7; i <= 10; i++) tick(1, 8'(i), 0, 0, 0);
        for (int i = 5; i <= 10; i++) begin
            tick(0, 8'h00, 1, 0, 0);
            if (rd_data !== 8'(i) || rd_valid !== 1'b1) errs++;
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL order_wrap: %0d out-of-order pops, want 0", errs);
        end
        checks++;
        if (level !== 4'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL order_level: level=%0d want 0", level);
        end
    endtask

    task automatic test_overflow();
        int errs = 0;
        for (int i = 0; i < 8; i++) tick(1, 8'h10 + 8'(i), 0, 0, 0);
        checks++;
        if (full !== 1'b1 || level !== 4'd8) begin
            failures++;
            $display("FAIL ovf_full: full=%b level=%0d want 1/8", full, level);
        end
        tick(1, 8'h18, 0, 0, 0);
        checks++;
        if (overflow !== 1'b1 || level !== 4'd8) begin
            failures++;
            $display("FAIL ovf_flag: ovf=%b level=%0d want 1/8", overflow, level);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 8'h00, 1, 0, 0);
            if (rd_data !== 8'h10 + 8'(i)) errs++;
        end
        checks++;
        if (errs != 0 || level !== 4'd0) begin
            failures++;
            $display("FAIL ovf_drain: errs=%0d level=%0d want 0/0", errs, level);
        end
        tick(0, 8'h00, 0, 0, 1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr: ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_full_simul();
        int errs = 0;
        for (int i = 0; i < 8; i++) tick(1, 8'h10 + 8'(i), 0, 0, 0);
        tick(1, 8'h20, 1, 0, 0);
        checks++;
        if (rd_data !== 8'h10 || level !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_simul: data=%h level=%0d ovf=%b want 10/8/0",
                     rd_data, level, overflow);
        end
        for (int i = 1; i < 8; i++) begin
            tick(0, 8'h00, 1, 0, 0);
            if (rd_data !== 8'h10 + 8'(i)) errs++;
        end
        tick(0, 8'h00, 1, 0, 0);
        checks++;
        if (errs != 0 || rd_data !== 8'h20) begin
            failures++;
            $display("FAIL full_simul_tail: errs=%0d last=%h want 0/20", errs, rd_data);
        end
    endtask

    task automatic test_underflow();
        tick(0, 8'h00, 1, 0, 0);
        checks++;
        if (rd_valid !== 1'b0 || underflow !== 1'b1) begin
            failures++;
            $display("FAIL udf_empty: vld=%b udf=%b want 0/1", rd_valid, underflow);
        end
        tick(0, 8'h00, 0, 0, 1);
        tick(1, 8'h33, 1, 0, 0);
        checks++;
        if (level !== 4'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL udf_simul: level=%0d udf=%b vld=%b want 1/1/0",
                     level, underflow, rd_valid);
        end
        tick(0, 8'h00, 1, 0, 0);
        checks++;
        if (rd_data !== 8'h33 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL udf_pop: data=%h vld=%b want 33/1", rd_data, rd_valid);
        end
    endtask

    task automatic test_flush();
        tick(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 8'h40 + 8'(i), 0, 0, 0);
        tick(1, 8'h55, 1, 1, 0);
        checks++;
        if (level !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0 ||
            rd_data !== 8'h33 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL flush: level=%0d e=%b v=%b d=%h u=%b want 0/1/0/33/0",
                     level, empty, rd_valid, rd_data, underflow);
        end
    endtask

    task automatic test_irq();
        for (int i = 0; i < 3; i++) tick(1, 8'h60 + 8'(i), 0, 0, 0);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_below: irq=%b want 0", irq);
        end
        tick(1, 8'h63, 0, 0, 0);
        checks++;
`ifdef SPI_RX_FIFO_IRQ_EN
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_thresh: irq=%b want 1", irq);
        end
`else
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_disabled: irq=%b want 0", irq);
        end
`endif
        tick(0, 8'h00, 1, 0, 0);
        checks++;
        if (irq !== 1'b0 || rd_data !== 8'h60) begin
            failures++;
            $display("FAIL irq_drop: irq=%b data=%h want 0/60", irq, rd_data);
        end
        tick(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int n = 0; n < 600; n++) begin
            tick($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6);
            checks++;
            if (level !== 4'(q.size()) || empty !== (q.size() == 0) ||
                full !== (q.size() == DEPTH) || rd_valid !== m_vld ||
                rd_data !== m_data || overflow !== m_ovf ||
                underflow !== m_udf || irq !== m_irq) begin
                failures++;
                errs++;
                if (errs < 5)
                    $display("FAIL random[%0d]: lvl=%0d/%0d v=%b/%b d=%h/%h o=%b/%b u=%b/%b i=%b/%b",
                             n, level, q.size(), rd_valid, m_vld, rd_data, m_data,
                             overflow, m_ovf, underflow, m_udf, irq, m_irq);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) tick(1, 8'h70 + 8'(i), 0, 0, 0);
        tick(1, 8'h80, 1, 0, 0);
        tick(0, 8'h00, 1, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        checks++;
        if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
            rd_valid !== 1'b0 || rd_data !== 8'h00 ||
            overflow !== 1'b0 || underflow !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: lvl=%0d e=%b v=%b d=%h o=%b u=%b i=%b",
                     level, empty, rd_valid, rd_data, overflow, underflow, irq);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        tick(1, 8'h99, 0, 0, 0);
        tick(0, 8'h00, 1, 0, 0);
        checks++;
        if (rd_data !== 8'h99 || level !== 4'd0) begin
            failures++;
            $display("FAIL after_reset: data=%h level=%0d want 99/0", rd_data, level);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_order_wrap();
        test_overflow();
        test_full_simul();
        test_underflow();
        test_flush();
        test_irq();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_rx_fifo.md
Name: spi_rx_fifo

Overview:
- Receive-side byte FIFO directly downstream of the SPI wrapper, in the `clk` domain.
- Captures each single-cycle `rx_valid`/`rx_buff` byte pulse from the wrapper.
- Buffers bytes so the CPU-side CSR logic can drain them at its own pace through a read-enable handshake.
- Reports level, full/empty and sticky overflow/underflow flags.

Parameters:
- DEPTH, 8, number of byte entries; power of two, minimum 2.
- ADDR_W, 3, pointer width; must equal log2(DEPTH).
- IRQ_THRESH, 4, level at or above which irq asserts (optional feature only); range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- rx_buff  in  8  received byte from the SPI wrapper; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle pulse; write request.
- rd_en  in  1  read request from CPU side.
- rd_data  out  8  popped byte, registered.
- rd_valid  out  1  one-cycle pulse; rd_data updated this cycle.
- flush  in  1  synchronous clear of contents and flags.
- clr_err  in  1  synchronous clear of sticky flags only.
- level  out  ADDR_W+1  current entry count, 0..DEPTH.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- overflow  out  1  sticky; a byte was dropped.
- underflow  out  1  sticky; rd_en issued while empty.
- irq  out  1  level/overflow interrupt (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, rd_ptr=0, level=0.
  - rd_data=8'h00, rd_valid=0, overflow=0, underflow=0, irq=0.
  - empty=1, full=0.
  - Storage array is not reset.
- Storage: DEPTH x 8 register array, written at wr_ptr. Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
- Write:
  - On rx_valid=1 and not full: store rx_buff at wr_ptr, then wr_ptr+1 and level+1.
  - Written data is readable no earlier than the next cycle; no write-to-read bypass.
- Read:
  - On rd_en=1 and not empty: rd_data <= mem[rd_ptr], rd_valid <= 1 on the next edge, then rd_ptr+1 and level-1.
  - Read latency is 1 clk.
  - rd_data holds its last value when no pop occurs.
  - rd_valid is 0 in every cycle without a successful pop.
- Empty read: rd_en=1 while empty means no pop, rd_valid stays 0, underflow <= 1.
- Full write: rx_valid=1 while full means the byte is dropped, overflow <= 1. Storage and pointers are unchanged.
- Simultaneous rx_valid and rd_en, level evaluated at the start of the cycle:
  - 0 < level < DEPTH: both accepted, level unchanged, both pointers advance.
  - level == DEPTH: pop accepted and push also accepted; space freed the same cycle, no overflow, level stays DEPTH.
  - level == 0: push accepted, pop rejected, underflow set, level becomes 1.
- Flush:
  - flush=1 clears pointers, level, overflow and underflow on the next edge.
  - It has priority over any concurrent push or pop; both are discarded.
  - rd_valid=0 that cycle; rd_data is unchanged.
- clr_err: clears overflow and underflow on the next edge. If an error event occurs in the same cycle, the set wins.
- Derived outputs: empty and full are combinational from level; level is registered.
- No state machine beyond the pointer/count registers; the rx_valid pulse is consumed directly, with no edge detection (the upstream block already pulses for exactly 1 cycle).

Optional Feature:
- Macro: SPI_RX_FIFO_IRQ_EN.
- Defined: irq is a registered output that asserts on the edge after (next-state level >= IRQ_THRESH) or overflow==1. It deasserts on the edge after both conditions clear (for example after a drain below threshold plus clr_err).
- Undefined: irq is tied to 1'b0. The threshold comparator and irq register are not built, and IRQ_THRESH is ignored.

Test Plan:
- Reset/basic:
  - Reset -> level=0, empty=1, full=0, rd_valid=0, rd_data=00, overflow=0, underflow=0.
  - Push 8'hA5 -> level=1.
  - rd_en -> next cycle rd_data=A5, rd_valid=1, empty=1.
- Order/wrap:
  - Push 8'h01..8'h06, pop 4, push 8'h07..8'h0A (pointers wrap).
  - Pop all -> output order 01..0A, final level=0.
- Overflow:
  - Push 8'h10..8'h17 -> full=1.
  - Push 8'h18 -> overflow=1, level=8.
  - Drain -> 10..17, with 18 absent.
  - clr_err -> overflow=0.
- Full simultaneous: at level 8 (10..17), pulse rx_valid=8'h20 together with rd_en -> rd_data=10, level=8, overflow=0, and the last drained byte is 20.
- Empty/underflow:
  - rd_en while empty -> rd_valid=0, underflow=1.
  - At level 0, rx_valid 8'h33 with rd_en -> level=1, underflow=1, next pop returns 33.
- Flush/async reset:
  - With level 5, flush concurrent with a push -> level=0 next cycle, empty=1.
  - With SPI_RX_FIFO_IRQ_EN and IRQ_THRESH=4: 4th push -> irq=1 next cycle; pop one -> irq=0.
  - Asserting rst_n=0 mid-stream -> all outputs reach their reset values immediately, without waiting for a clk edge.
